exception_flush_ctrl: RTL and testbench

//  Sequences the pipeline response to a committed exception or ERET at WB. Raises flush to all

---
 rtl/exception_flush_ctrl_if.sv | 18 +
 rtl/exception_flush_ctrl.sv | 117 +++++++++++
 tb/tb_exception_flush_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/exception_flush_ctrl_if.sv
// Redirect handshake between the exception flush controller (master) and IF (slave).
interface exception_flush_ctrl_if;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/exception_flush_ctrl.sv
// Flushes the pipeline on a committed exception/ERET, drains outstanding bus traffic,
// then hands the exception vector or EPC to IF over a valid/ready handshake.
module exception_flush_ctrl #(
  parameter logic [31:0] EX_VECTOR     = 32'hBFC0_0380,
  parameter int          OUTSTANDING_W = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ws_valid,
  input  logic                          ex_en,
  input  logic                          eret_flush,
  input  logic [31:0]                   c0_epc,
  input  logic                          inst_req_fire,
  input  logic                          inst_data_ok,
  input  logic                          data_req_fire,
  input  logic                          data_data_ok,
  exception_flush_ctrl_if.master        redir,
  output logic                          flush,
  output logic                          busy,
  output logic                          drain_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_target;
  logic [31:0] r_redirect_pc;
  logic        r_redirect_valid;
  logic        r_drain_err;

  logic        w_event;
  logic [1:0]  w_inc;
  logic [1:0]  w_dec;
  logic [1:0]  w_zero;
  logic [1:0]  w_ovf;
  logic [1:0]  w_unf;

  assign w_event = ws_valid & (ex_en | eret_flush);
  assign w_inc   = {data_req_fire, inst_req_fire};
  assign w_dec   = {data_data_ok, inst_data_ok};

  // Channel 0 tracks instruction-side traffic, channel 1 data-side traffic.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      localparam logic [OUTSTANDING_W-1:0] CNT_MAX = '1;
      logic [OUTSTANDING_W-1:0] r_cnt;
      logic                     w_up;
      logic                     w_down;

      assign w_up       = w_inc[gi] & ~w_dec[gi];
      assign w_down     = w_dec[gi] & ~w_inc[gi];
      assign w_ovf[gi]  = w_up & (r_cnt == CNT_MAX);
      assign w_unf[gi]  = w_down & (r_cnt == '0);
      assign w_zero[gi] = (r_cnt == '0);

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (w_up && !w_ovf[gi]) begin
          r_cnt <= r_cnt + OUTSTANDING_W'(1);
        end else if (w_down && !w_unf[gi]) begin
          r_cnt <= r_cnt - OUTSTANDING_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_target         <= '0;
      r_redirect_pc    <= '0;
      r_redirect_valid <= 1'b0;
      r_drain_err      <= 1'b0;
    end else begin
      r_drain_err <= r_drain_err | (|w_ovf) | (|w_unf);
      case (r_state)
        IDLE: begin
          if (w_event) begin
            r_target <= ex_en ? EX_VECTOR : c0_epc;
            r_state  <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave only once both registered counts are zero, so a late request extends the drain.
          if (&w_zero) begin
            r_state          <= REDIRECT;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= r_target;
          end
        end
        REDIRECT: begin
          if (redir.redirect_ready) begin
            r_state          <= IDLE;
            r_redirect_valid <= 1'b0;
          end
        end
        default: begin
          r_state          <= IDLE;
          r_redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  // Flush must be visible in the event cycle itself, ahead of the state register.
  assign flush = (r_state == DRAIN) | ((r_state == IDLE) & w_event);
  assign busy  = (r_state != IDLE);
  assign drain_err = r_drain_err;
  assign redir.redirect_valid = r_redirect_valid;
  assign redir.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_exception_flush_ctrl.sv
// Randomized + directed bench: a per-cycle model feeds an expectation queue and a redirect
// queue; a negedge monitor pops and compares against the DUT.
module tb_exception_flush_ctrl;
  localparam int          W    = 2;
  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam int          CMAX = (1 << W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid, ex_en, eret_flush;
  logic [31:0] c0_epc;
  logic        inst_req_fire, inst_data_ok, data_req_fire, data_data_ok;
  logic        flush, busy, drain_err;

  exception_flush_ctrl_if rif ();

  exception_flush_ctrl #(.EX_VECTOR(VEC), .OUTSTANDING_W(W)) dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ex_en(ex_en), .eret_flush(eret_flush),
    .c0_epc(c0_epc), .inst_req_fire(inst_req_fire), .inst_data_ok(inst_data_ok),
    .data_req_fire(data_req_fire), .data_data_ok(data_data_ok), .redir(rif.master),
    .flush(flush), .busy(busy), .drain_err(drain_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        flush;
    logic        busy;
    logic        rv;
    logic        chk_pc;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] redir_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: phase 0 idle, 1 flushing/draining, 2 offering redirect.
  int          m_phase, m_ic, m_dc;
  bit          m_err;
  logic [31:0] m_tgt, m_pc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, req);
    end
  endtask

  task automatic cnt_upd(inout int c, input bit inc, input bit dec);
    if (inc && !dec) begin
      if (c == CMAX) m_err = 1'b1; else c++;
    end else if (dec && !inc) begin
      if (c == 0) m_err = 1'b1; else c--;
    end
  endtask

  task automatic clr();
    reset = 0; ws_valid = 0; ex_en = 0; eret_flush = 0;
    inst_req_fire = 0; inst_data_ok = 0; data_req_fire = 0; data_data_ok = 0;
  endtask

  task automatic step();
    exp_t e;
    bit   ev;
    ev       = ws_valid && (ex_en || eret_flush);
    e.flush  = (m_phase == 1) || (m_phase == 0 && ev);
    e.busy   = (m_phase != 0);
    e.rv     = (m_phase == 2);
    e.chk_pc = (m_phase != 1);
    e.pc     = m_pc;
    e.err    = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    if (reset) begin
      m_phase = 0; m_ic = 0; m_dc = 0; m_err = 0; m_pc = 0; m_tgt = 0;
      redir_q.delete();
    end else begin
      case (m_phase)
        0: if (ev) begin
             m_tgt   = ex_en ? VEC : c0_epc;
             m_phase = 1;
             redir_q.push_back(m_tgt);
           end
        1: if (m_ic == 0 && m_dc == 0) begin m_phase = 2; m_pc = m_tgt; end
        default: if (rif.redirect_ready) m_phase = 0;
      endcase
      cnt_upd(m_ic, inst_req_fire, inst_data_ok);
      cnt_upd(m_dc, data_req_fire, data_data_ok);
    end
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic event_cycle(bit ex, bit er, logic [31:0] epc);
    ws_valid = 1; ex_en = ex; eret_flush = er; c0_epc = epc;
    step();
    ws_valid = 0; ex_en = 0; eret_flush = 0;
  endtask

  // Monitor: per-cycle output comparison and redirect handshake scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("flush", {31'd0, flush}, {31'd0, e.flush});
        chk("busy", {31'd0, busy}, {31'd0, e.busy});
        chk("redirect_valid", {31'd0, rif.redirect_valid}, {31'd0, e.rv});
        chk("drain_err", {31'd0, drain_err}, {31'd0, e.err});
        if (e.chk_pc) chk("redirect_pc", rif.redirect_pc, e.pc);
      end
      if (rif.redirect_valid === 1'b1 && rif.redirect_ready === 1'b1) begin
        if (redir_q.size() == 0) begin
          chk("unexpected_handshake", rif.redirect_pc, 32'hxxxx_xxxx);
        end else begin
          chk("handshake_pc", rif.redirect_pc, redir_q.pop_front());
        end
      end
    end
  end

  initial begin
    clr();
    c0_epc = 0;
    rif.redirect_ready = 1;
    reset = 1;
    @(posedge clk); #1;
    m_phase = 0; m_ic = 0; m_dc = 0; m_err = 0; m_pc = 0; m_tgt = 0;
    step();                      // second reset cycle, checks reset values
    reset = 0;
    steps(2);

    // 1: exception with empty counters
    event_cycle(1, 0, 32'h1111_2222);
    steps(4);

    // 2: ERET with two outstanding data requests
    data_req_fire = 1; steps(2); data_req_fire = 0;
    event_cycle(0, 1, 32'h8000_1234);
    steps(2);
    data_data_ok = 1; step(); data_data_ok = 0;
    step();
    data_data_ok = 1; step(); data_data_ok = 0;
    steps(4);

    // 3: exception and ERET together
    event_cycle(1, 1, 32'h8000_5678);
    steps(4);

    // 4: IF stalls the redirect for four cycles; ignored event during drain
    rif.redirect_ready = 0;
    event_cycle(0, 1, 32'h9000_00A0);
    event_cycle(1, 0, 32'h0);
    steps(4);
    rif.redirect_ready = 1;
    steps(3);

    // 5: saturation sets sticky error; simultaneous fire+ok keeps drain going
    data_req_fire = 1; steps(4); data_req_fire = 0;
    data_data_ok = 1; steps(2); data_data_ok = 0;
    event_cycle(1, 0, 32'h0);
    data_req_fire = 1; data_data_ok = 1; steps(3);
    data_req_fire = 0; steps(2);
    steps(4);
    inst_data_ok = 1; step(); inst_data_ok = 0;   // underflow: error stays set
    steps(2);

    // 6: reset in the middle of a drain
    reset = 1; step(); reset = 0;
    inst_req_fire = 1; steps(2); inst_req_fire = 0;
    event_cycle(0, 1, 32'hA000_0044);
    steps(2);
    reset = 1; step(); reset = 0;
    steps(5);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      clr();
      reset         = ($urandom_range(0, 299) == 0);
      ws_valid      = ($urandom_range(0, 7) == 0);
      ex_en         = $urandom_range(0, 1);
      eret_flush    = $urandom_range(0, 1);
      c0_epc        = $urandom;
      inst_req_fire = ($urandom_range(0, 3) == 0);
      data_req_fire = ($urandom_range(0, 3) == 0);
      inst_data_ok  = (m_ic > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      data_data_ok  = (m_dc > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      rif.redirect_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    // Quiesce so every pending redirect completes
    clr();
    rif.redirect_ready = 1;
    for (int i = 0; i < 30; i++) begin
      inst_data_ok = (m_ic > 0);
      data_data_ok = (m_dc > 0);
      step();
    end
    clr();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    chk("pending_cycle_checks", exp_q.size(), 0);
    chk("pending_redirects", redir_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
